// File: rtl/qerv_wb_ram_responder.sv
// Wishbone-classic data-memory responder: byte-masked writes, registered read
// data and a programmable number of wait states before the single-cycle ack.
module qerv_wb_ram_responder #(
    parameter int    DEPTH       = 256,
    parameter int    WAIT_STATES = 0,
    parameter string MEMFILE     = ""
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [$clog2(DEPTH)-1:0] i_wb_adr,
    input  logic [31:0]              i_wb_dat,
    input  logic [3:0]               i_wb_sel,
    input  logic                     i_wb_we,
    input  logic                     i_wb_cyc,
    output logic [31:0]              o_wb_rdt,
    output logic                     o_wb_ack
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WORDS = DEPTH / 4;
    localparam int IW    = (AW > 2) ? AW - 2 : 1;
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           commit;
    logic [IW-1:0]  idx;
    logic [31:0]    mem [WORDS];

    // Byte offset bits are dropped; the shift keeps this legal for DEPTH == 4.
    assign idx = IW'(i_wb_adr >> 2);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (i_wb_cyc) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end else begin
                        commit    = 1'b1;
                        state_nxt = ACK;
                    end
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    commit    = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            o_wb_ack <= 1'b0;
            o_wb_rdt <= 32'h0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            o_wb_ack <= commit;
            if (commit && !i_wb_we)
                o_wb_rdt <= mem[idx];
        end
    end

    // Storage has no reset; only the write enable is suppressed while in reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && commit && i_wb_we) begin
            for (int n = 0; n < 4; n++) begin
                if (i_wb_sel[n])
                    mem[idx][8*n +: 8] <= i_wb_dat[8*n +: 8];
            end
        end
    end

endmodule
